// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and widths for the memory pipeline stage.
//   mem_op_t    : memory operation decode (value 3 is reserved, treated as none)
//   mem_size_t  : access size encoding (1/2/4/8 bytes)
//   mem_state_t : memory stage transaction state
// ----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int unsigned DataW  = 64;
    localparam int unsigned AddrW  = 64;
    localparam int unsigned RegW   = 4;
    localparam int unsigned FlagsW = 64;

    typedef enum logic [1:0] {
        MemNone  = 2'd0,
        MemLoad  = 2'd1,
        MemStore = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SizeB1 = 2'd0,
        SizeB2 = 2'd1,
        SizeB4 = 2'd2,
        SizeB8 = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if
// Bundles the three buses around the memory stage:
//   ALU side   : exe_mem, result, rflags, mem_op, mem_size, mem_sext, dst_reg
//                (to stage), mem_blocked (from stage)
//   memory port: req_valid/req_addr/req_we/req_size/req_wdata (from stage),
//                req_ready/resp_valid/resp_rdata (to stage)
//   writeback  : wb_valid, wb_reg, wb_data, wb_rflags (from stage)
// Modports: slave = the memory stage, master = everything around it.
// ----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int unsigned DATA_W = mem_stage_pkg::DataW,
    parameter int unsigned ADDR_W = mem_stage_pkg::AddrW,
    parameter int unsigned REG_W  = mem_stage_pkg::RegW
);

    // ALU side; result[63:0] is value/address, result[127:64] is store data
    logic                              exe_mem;
    logic [2*DATA_W-1:0]               result;
    logic [mem_stage_pkg::FlagsW-1:0]  rflags;
    logic [1:0]                        mem_op;
    logic [1:0]                        mem_size;
    logic                              mem_sext;
    logic [REG_W-1:0]                  dst_reg;
    logic                              mem_blocked;

    // Data memory port
    logic                              req_valid;
    logic                              req_ready;
    logic [ADDR_W-1:0]                 req_addr;
    logic                              req_we;
    logic [1:0]                        req_size;
    logic [DATA_W-1:0]                 req_wdata;
    logic                              resp_valid;
    logic [DATA_W-1:0]                 resp_rdata;

    // Writeback
    logic                              wb_valid;
    logic [REG_W-1:0]                  wb_reg;
    logic [DATA_W-1:0]                 wb_data;
    logic [mem_stage_pkg::FlagsW-1:0]  wb_rflags;

    modport slave (
        input  exe_mem, result, rflags, mem_op, mem_size, mem_sext, dst_reg,
        output mem_blocked,
        output req_valid, req_addr, req_we, req_size, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        output wb_valid, wb_reg, wb_data, wb_rflags
    );

    modport master (
        output exe_mem, result, rflags, mem_op, mem_size, mem_sext, dst_reg,
        input  mem_blocked,
        input  req_valid, req_addr, req_we, req_size, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        input  wb_valid, wb_reg, wb_data, wb_rflags
    );

endinterface

// File: rtl/mem_stage_load_extend.sv
// ----------------------------------------------------------------------------
// mem_stage_load_extend (load_extend unit)
// Combinational load data extension; also reused by sign-extending MOV forms.
//   i_rdata : raw data, valid bytes in the low end
//   i_size  : 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
//   i_sext  : 1 = sign-extend, 0 = zero-extend
//   o_value : 64-bit extended value
// ----------------------------------------------------------------------------
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [DataW-1:0] i_rdata,
    input  logic [1:0]       i_size,
    input  logic             i_sext,
    output logic [DataW-1:0] o_value
);

    logic w_fill8;
    logic w_fill16;
    logic w_fill32;

    assign w_fill8  = i_sext & i_rdata[7];
    assign w_fill16 = i_sext & i_rdata[15];
    assign w_fill32 = i_sext & i_rdata[31];

    always_comb begin
        o_value = i_rdata;
        case (i_size)
            SizeB1:  o_value = {{(DataW-8){w_fill8}},   i_rdata[7:0]};
            SizeB2:  o_value = {{(DataW-16){w_fill16}}, i_rdata[15:0]};
            SizeB4:  o_value = {{(DataW-32){w_fill32}}, i_rdata[31:0]};
            default: o_value = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory pipeline stage behind the ALU. Non-memory ops go straight to
// writeback with one cycle of latency; loads/stores become a single
// outstanding request/response transaction on the data memory port, during
// which the ALU is stalled through mem_blocked.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : mem_stage_if slave modport (ALU input, memory port, writeback)
// ----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned REG_W  = RegW
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.slave    bus
);

    mem_state_t r_state;
    mem_state_t w_state_next;

    // Latched memory op
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic              r_sext;
    logic              r_we;
    logic [REG_W-1:0]  r_dst;
    logic [FlagsW-1:0] r_rflags;

    // Writeback registers and their next values
    logic              r_wb_valid;
    logic [REG_W-1:0]  r_wb_reg;
    logic [DATA_W-1:0] r_wb_data;
    logic [FlagsW-1:0] r_wb_rflags;
    logic              w_wb_valid;
    logic [REG_W-1:0]  w_wb_reg;
    logic [DATA_W-1:0] w_wb_data;
    logic [FlagsW-1:0] w_wb_rflags;

    logic              w_is_mem;
    logic              w_capture_mem;
    logic [DATA_W-1:0] w_ext;

    // mem_op = 3 falls out as a non-memory op here
    assign w_is_mem      = (bus.mem_op == MemLoad) || (bus.mem_op == MemStore);
    assign w_capture_mem = (r_state == StIdle) && bus.exe_mem && w_is_mem;

    mem_stage_load_extend u_load_extend (
        .i_rdata (bus.resp_rdata),
        .i_size  (r_size),
        .i_sext  (r_sext),
        .o_value (w_ext)
    );

    always_comb begin
        w_state_next = r_state;
        w_wb_valid   = 1'b0;
        w_wb_reg     = r_wb_reg;
        w_wb_data    = r_wb_data;
        w_wb_rflags  = r_wb_rflags;
        case (r_state)
            StIdle: begin
                if (bus.exe_mem) begin
                    if (w_is_mem) begin
                        w_state_next = StReq;
                    end else begin
                        w_wb_valid  = 1'b1;
                        w_wb_reg    = bus.dst_reg;
                        w_wb_data   = bus.result[DATA_W-1:0];
                        w_wb_rflags = bus.rflags;
                    end
                end
            end
            StReq: begin
                if (bus.req_ready) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (bus.resp_valid) begin
                    w_state_next = StIdle;
                    // Store acks complete silently
                    if (!r_we) begin
                        w_wb_valid  = 1'b1;
                        w_wb_reg    = r_dst;
                        w_wb_data   = w_ext;
                        w_wb_rflags = r_rflags;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_wb_valid  <= 1'b0;
            r_wb_reg    <= '0;
            r_wb_data   <= '0;
            r_wb_rflags <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wb_valid  <= w_wb_valid;
            r_wb_reg    <= w_wb_reg;
            r_wb_data   <= w_wb_data;
            r_wb_rflags <= w_wb_rflags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_size   <= '0;
            r_sext   <= 1'b0;
            r_we     <= 1'b0;
            r_dst    <= '0;
            r_rflags <= '0;
        end else if (w_capture_mem) begin
            r_addr   <= bus.result[ADDR_W-1:0];
            r_wdata  <= bus.result[2*DATA_W-1:DATA_W];
            r_size   <= bus.mem_size;
            r_sext   <= bus.mem_sext;
            r_we     <= (bus.mem_op == MemStore);
            r_dst    <= bus.dst_reg;
            r_rflags <= bus.rflags;
        end
    end

    // Stall comes from the state register only, never combinationally from exe_mem
    assign bus.mem_blocked = (r_state != StIdle);
    assign bus.req_valid   = (r_state == StReq);
    assign bus.req_addr    = r_addr;
    assign bus.req_we      = r_we;
    assign bus.req_size    = r_size;
    assign bus.req_wdata   = r_wdata;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_reg      = r_wb_reg;
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_rflags   = r_wb_rflags;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage. Expected writebacks are queued when an op is
// driven and compared by a monitor whenever wb_valid is seen.
// ----------------------------------------------------------------------------
module tb_mem_stage;

    typedef struct packed {
        logic [3:0]  rd;
        logic [63:0] data;
        logic [63:0] flags;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t q[$];

    mem_stage_if bus ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Writeback scoreboard
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            n_vec++;
            assert (q.size() != 0)
            else begin
                n_err++;
                $error("FAIL wb_unexpected got reg=%0d data=%h exp=no writeback",
                       bus.wb_reg, bus.wb_data);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("wb_reg", {124'b0, bus.wb_reg}, {124'b0, e.rd});
                chk("wb_data", {64'b0, bus.wb_data}, {64'b0, e.data});
                chk("wb_rflags", {64'b0, bus.wb_rflags}, {64'b0, e.flags});
            end
        end
    end

    task automatic drive_op(input logic [1:0] op, input logic [127:0] res, input logic [1:0] size,
                            input logic sext, input logic [3:0] rd, input logic [63:0] flags);
        bus.exe_mem  = 1'b1;
        bus.mem_op   = op;
        bus.result   = res;
        bus.mem_size = size;
        bus.mem_sext = sext;
        bus.dst_reg  = rd;
        bus.rflags   = flags;
    endtask

    task automatic idle_alu();
        bus.exe_mem = 1'b0;
        bus.mem_op  = 2'd0;
        bus.result  = '1;
    endtask

    // Load with req_ready already high; response in the first WAIT cycle
    task automatic do_load(input logic [1:0] size, input logic sext, input logic [63:0] rdata,
                           input logic [63:0] exp, input logic [3:0] rd);
        logic [63:0] flags;
        flags = {60'h0, rd} * 64'h101;
        drive_op(2'd1, {64'h0, 64'h5000}, size, sext, rd, flags);
        bus.req_ready = 1'b1;
        q.push_back('{rd: rd, data: exp, flags: flags});
        @(negedge clk);
        idle_alu();
        chk("ld_req_valid", {127'b0, bus.req_valid}, 128'd1);
        @(negedge clk);
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        chk("ld_wb_valid", {127'b0, bus.wb_valid}, 128'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.exe_mem    = 1'b0;
        bus.result     = '0;
        bus.rflags     = '0;
        bus.mem_op     = '0;
        bus.mem_size   = '0;
        bus.mem_sext   = 1'b0;
        bus.dst_reg    = '0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_blocked", {127'b0, bus.mem_blocked}, 128'd0);
        chk("rst_req_valid", {127'b0, bus.req_valid}, 128'd0);
        chk("rst_wb_valid", {127'b0, bus.wb_valid}, 128'd0);
        chk("rst_req_addr", {64'b0, bus.req_addr}, 128'd0);
        chk("rst_wb_data", {64'b0, bus.wb_data}, 128'd0);
        reset = 1'b0;

        // Pass-through, back to back, last op uses reserved mem_op = 3
        drive_op(2'd0, 128'h1234, 2'd0, 1'b0, 4'd3, 64'h11);
        q.push_back('{rd: 4'd3, data: 64'h1234, flags: 64'h11});
        @(negedge clk);
        chk("pt_wbv0", {127'b0, bus.wb_valid}, 128'd1);
        chk("pt_blk0", {127'b0, bus.mem_blocked}, 128'd0);
        drive_op(2'd0, 128'h5678, 2'd0, 1'b0, 4'd8, 64'h22);
        q.push_back('{rd: 4'd8, data: 64'h5678, flags: 64'h22});
        @(negedge clk);
        chk("pt_wbv1", {127'b0, bus.wb_valid}, 128'd1);
        chk("pt_blk1", {127'b0, bus.mem_blocked}, 128'd0);
        drive_op(2'd3, 128'h9abc, 2'd0, 1'b0, 4'd15, 64'h33);
        q.push_back('{rd: 4'd15, data: 64'h9abc, flags: 64'h33});
        @(negedge clk);
        chk("pt_wbv2", {127'b0, bus.wb_valid}, 128'd1);
        chk("pt_blk2", {127'b0, bus.mem_blocked}, 128'd0);
        idle_alu();
        @(negedge clk);
        chk("pt_wbv_end", {127'b0, bus.wb_valid}, 128'd0);

        // Byte load, sign-extended, two wait cycles
        drive_op(2'd1, {64'h0, 64'h1000}, 2'd0, 1'b1, 4'd5, 64'hAA);
        q.push_back('{rd: 4'd5, data: 64'hFFFF_FFFF_FFFF_FF80, flags: 64'hAA});
        @(negedge clk);
        idle_alu();
        chk("ld_blk_req", {127'b0, bus.mem_blocked}, 128'd1);
        chk("ld_req_valid", {127'b0, bus.req_valid}, 128'd1);
        chk("ld_req_addr", {64'b0, bus.req_addr}, 128'h1000);
        chk("ld_req_we", {127'b0, bus.req_we}, 128'd0);
        chk("ld_req_size", {126'b0, bus.req_size}, 128'd0);
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        chk("ld_req_drop", {127'b0, bus.req_valid}, 128'd0);
        chk("ld_blk_w1", {127'b0, bus.mem_blocked}, 128'd1);
        @(negedge clk);
        chk("ld_blk_w2", {127'b0, bus.mem_blocked}, 128'd1);
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 64'hABCD_0000_0000_0080;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        chk("ld_blk_done", {127'b0, bus.mem_blocked}, 128'd0);
        chk("ld_wbv", {127'b0, bus.wb_valid}, 128'd1);

        // Store with req_ready low for 3 cycles; response on the accept edge ignored
        drive_op(2'd2, {64'hDEAD_BEEF, 64'h2000}, 2'd2, 1'b0, 4'd7, 64'h44);
        @(negedge clk);
        idle_alu();
        for (int i = 0; i < 3; i++) begin
            chk("st_req_valid", {127'b0, bus.req_valid}, 128'd1);
            chk("st_req_addr", {64'b0, bus.req_addr}, 128'h2000);
            chk("st_req_wdata", {64'b0, bus.req_wdata}, 128'hDEAD_BEEF);
            chk("st_req_we", {127'b0, bus.req_we}, 128'd1);
            chk("st_req_size", {126'b0, bus.req_size}, 128'd2);
            @(negedge clk);
        end
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b1;
        @(negedge clk);
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        chk("st_req_drop", {127'b0, bus.req_valid}, 128'd0);
        chk("st_early_resp", {127'b0, bus.mem_blocked}, 128'd1);
        bus.resp_valid = 1'b1;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        chk("st_blk_done", {127'b0, bus.mem_blocked}, 128'd0);
        chk("st_no_wb", {127'b0, bus.wb_valid}, 128'd0);
        @(negedge clk);
        chk("st_no_wb2", {127'b0, bus.wb_valid}, 128'd0);

        // Load followed by a NONE op held during the stall
        drive_op(2'd1, {64'h0, 64'h3000}, 2'd3, 1'b0, 4'd2, 64'h1);
        bus.req_ready = 1'b1;
        q.push_back('{rd: 4'd2, data: 64'h0123_4567_89AB_CDEF, flags: 64'h1});
        @(negedge clk);
        drive_op(2'd0, 128'h5555, 2'd0, 1'b0, 4'd9, 64'h22);
        q.push_back('{rd: 4'd9, data: 64'h5555, flags: 64'h22});
        chk("stall_blk", {127'b0, bus.mem_blocked}, 128'd1);
        @(negedge clk);
        chk("stall_wbv_wait", {127'b0, bus.wb_valid}, 128'd0);
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        chk("stall_ld_wbv", {127'b0, bus.wb_valid}, 128'd1);
        chk("stall_blk_idle", {127'b0, bus.mem_blocked}, 128'd0);
        @(negedge clk);
        idle_alu();
        chk("stall_none_wbv", {127'b0, bus.wb_valid}, 128'd1);
        @(negedge clk);
        chk("stall_once", {127'b0, bus.wb_valid}, 128'd0);
        bus.req_ready = 1'b0;

        // Reset in WAIT, then a stale response
        drive_op(2'd1, {64'h0, 64'h4000}, 2'd3, 1'b0, 4'd4, 64'h5);
        bus.req_ready = 1'b1;
        @(negedge clk);
        idle_alu();
        @(negedge clk);
        bus.req_ready = 1'b0;
        chk("rmid_blk_wait", {127'b0, bus.mem_blocked}, 128'd1);
        #2 reset = 1'b1;
        #1;
        chk("rmid_blk", {127'b0, bus.mem_blocked}, 128'd0);
        chk("rmid_req_valid", {127'b0, bus.req_valid}, 128'd0);
        chk("rmid_req_addr", {64'b0, bus.req_addr}, 128'd0);
        chk("rmid_wb_valid", {127'b0, bus.wb_valid}, 128'd0);
        chk("rmid_wb_data", {64'b0, bus.wb_data}, 128'd0);
        chk("rmid_wb_reg", {124'b0, bus.wb_reg}, 128'd0);
        chk("rmid_wb_rflags", {64'b0, bus.wb_rflags}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = '1;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        chk("rmid_stale_wbv", {127'b0, bus.wb_valid}, 128'd0);
        chk("rmid_stale_blk", {127'b0, bus.mem_blocked}, 128'd0);
        @(negedge clk);
        chk("rmid_stale_wbv2", {127'b0, bus.wb_valid}, 128'd0);

        // Extension widths
        do_load(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF, 4'd6);
        do_load(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 4'd10);
        do_load(2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 4'd11);
        do_load(2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_7FFF, 64'h0000_0000_0000_7FFF, 4'd12);
        do_load(2'd0, 1'b0, 64'h1234_5678_9ABC_DEFF, 64'h0000_0000_0000_00FF, 4'd13);
        do_load(2'd3, 1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'd14);
        bus.req_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("sb_drained", 128'(q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage downstream of the ALU; the consumer end of the exe_mem / result / mem_blocked interface.
- Captures each valid ALU output and passes non-memory ops straight to writeback.
- Load and store ops become a single-outstanding request/response transaction to the data memory port.
- Back-pressures the ALU through mem_blocked while a memory transaction is in flight.

Parameters:
- DATA_W, 64, width of register and memory data.
- ADDR_W, 64, width of the effective address.
- REG_W, 4, width of the architectural register index (16 GPRs).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- exe_mem  in  1  ALU output valid.
- result  in  128  [63:0] = ALU value or effective address; [127:64] = store data.
- rflags  in  64  flags produced with result.
- mem_op  in  2  0 = NONE, 1 = LOAD, 2 = STORE, 3 = reserved (treated as NONE).
- mem_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
- mem_sext  in  1  load sign-extend (1) or zero-extend (0).
- dst_reg  in  REG_W  writeback register index.
- mem_blocked  out  1  stall to ALU.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  ADDR_W  request address.
- req_we  out  1  1 = store.
- req_size  out  2  access size.
- req_wdata  out  DATA_W  store data.
- resp_valid  in  1  memory response or store ack.
- resp_rdata  in  DATA_W  load data, in the low bytes.
- wb_valid  out  1  writeback strobe.
- wb_reg  out  REG_W  writeback register index.
- wb_data  out  DATA_W  writeback value.
- wb_rflags  out  64  flags written back.

Behaviour:
- Reset (asynchronous): state = IDLE. All outputs 0, including mem_blocked, req_valid and wb_valid.
- FSM states:
  - IDLE: no transaction; mem_blocked = 0.
  - REQ: req_valid = 1.
  - WAIT: awaiting resp_valid.
- mem_blocked = (state != IDLE). It is derived from the state register only; no combinational path from exe_mem.
- Capture occurs only in IDLE, on a clk edge with exe_mem = 1.
  - The ALU also advances on that edge, so one item is consumed exactly once.
  - In REQ/WAIT, exe_mem and its payload are ignored. The ALU holds them, and they are captured on the first IDLE edge.
- NONE op, latency 1:
  - Next cycle: wb_valid = 1, wb_reg = dst_reg, wb_data = result[63:0], wb_rflags = rflags.
  - State stays IDLE, so back-to-back NONE ops give wb_valid every cycle.
- LOAD/STORE:
  - On capture, latch addr = result[63:0], wdata = result[127:64], size, sext, dst_reg and rflags. Go to REQ.
  - REQ: drive the req_* outputs from the latches. The request is accepted on an edge with req_ready = 1, then go to WAIT. req_ready may already be high in the first REQ cycle. req_* stay stable until accepted.
  - WAIT, LOAD: on resp_valid, register wb_valid = 1 and wb_data = extend(resp_rdata, size, sext), then go to IDLE.
    - Extension takes the low 8/16/32/64 bits, then zero- or sign-extends to 64 bits.
  - WAIT, STORE: on resp_valid, go to IDLE with no writeback.
- wb_valid is a single-cycle pulse and is 0 in every cycle without a completion.
- wb_reg, wb_data and wb_rflags hold their last values when wb_valid = 0.
- resp_valid outside WAIT is ignored. This covers a stale response after reset, and a response in the same cycle the request is accepted.
- Minimum memory-op occupancy is 3 cycles (REQ, WAIT, IDLE capture).
- Reset mid-transaction: immediate return to IDLE; the latched op is dropped; no writeback.
- mem_op = 3 is treated as NONE.

Decomposition:
- Shared package (alongside the instruction and GPR headers):
  - mem_op_t enum (NONE, LOAD, STORE).
  - mem_size_t enum (B1, B2, B4, B8).
  - mem_state_t enum (IDLE, REQ, WAIT).
- One sub-module, load_extend: combinational; inputs rdata, size, sext; output 64-bit value. It is reused by the later sign-extending MOV forms.

Test Plan:
- Pass-through:
  - Stimulus: exe_mem = 1, mem_op = NONE, result = 0x1234, dst_reg = 3, for 3 consecutive cycles with new values.
  - Response: wb_valid each following cycle with matching data; mem_blocked never 1.
- Load with sign extension:
  - Stimulus: mem_op = LOAD, addr 0x1000, size = 1 B, sext = 1; memory returns rdata = 0x80 after 2 wait cycles.
  - Response: req_addr = 0x1000, req_we = 0; wb_data = 0xFFFF_FFFF_FFFF_FF80, wb_reg = dst_reg.
  - mem_blocked is high from the cycle after capture until the resp_valid edge.
- Store:
  - Stimulus: mem_op = STORE, result = {0xDEAD_BEEF, 0x2000}, size = 4 B; req_ready held low 3 cycles.
  - Response: req_valid and req_* stable for those cycles; req_wdata = 0xDEAD_BEEF, req_we = 1; no wb_valid after the ack.
- Stall/hold:
  - Stimulus: a load followed by a held NONE op with exe_mem kept high during the stall.
  - Response: the NONE op is written back exactly once, in the cycle after the stage returns to IDLE.
- Reset mid-op:
  - Stimulus: assert reset while in WAIT; after release, pulse resp_valid.
  - Response: all outputs 0 immediately; the stale response produces no wb_valid.
- Zero-extend widths:
  - Stimulus: rdata = 0xFFFF_FFFF_FFFF_FFFF with sext = 0 at sizes 2 B and 4 B.
  - Response: 0xFFFF and 0xFFFF_FFFF respectively.
